queen_solution_buffer: RTL and testbench

- Sits directly downstream of the 8-queen datapath.
- Captures each completed board as the datapath presents it row by row on its tri-state output bus: row 0 first, one-hot column per row.
- Holds up to two complete solutions in a ping-pong buffer and replays them on a valid/ready stream.
- Counts solutions and flags malformed rows; the controller stalls on `in_ready` when both banks are occupied.

---
 rtl/queen_solution_buffer.sv | 85 ++++++++
 tb/tb_queen_solution_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_solution_buffer.sv
// queen_solution_buffer: captures 8-queen boards row by row into a two-bank
// ping-pong store and replays them on a valid/ready stream.
`timescale 1ns/1ps
module queen_solution_buffer #(
    parameter int N = 8,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     in_row,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] sol_count,
    output logic             err_onehot
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [0:0] FILL = 1'b0, WAIT = 1'b1;
    localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;

    logic [N-1:0] mem [2][N];
    logic [1:0]    full, full_nx;
    logic          wbank, rbank, wbank_nx;
    logic [RW-1:0] wrow, rrow;
    logic [0:0]    wstate, rstate, wstate_nx, rstate_nx;
    logic          write, wdone, rhs, rdone;

    assign in_ready  = wstate == FILL;
    assign out_valid = rstate == SEND;
    assign out_data  = out_valid ? mem[rbank][rrow] : '0;
    assign out_last  = out_valid && rrow == LAST_ROW;
    // flush wins over a coincident row, which is then dropped
    assign write     = in_valid && in_ready && !flush;
    assign wdone     = write && wrow == LAST_ROW;
    assign rhs       = out_valid && out_ready;
    assign rdone     = rhs && rrow == LAST_ROW;
    assign wbank_nx  = wbank ^ wdone;

    always_comb begin
        full_nx = full;
        if (wdone) full_nx[wbank] = 1'b1;
        if (rdone) full_nx[rbank] = 1'b0;
        wstate_nx = full_nx[wbank_nx] ? WAIT : FILL;
        rstate_nx = (rstate == IDLE) ? (full[rbank] ? SEND : IDLE)
                  : (rdone ? (full[~rbank] ? SEND : IDLE) : SEND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full       <= '0;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wrow       <= '0;
            rrow       <= '0;
            wstate     <= FILL;
            rstate     <= IDLE;
            sol_count  <= '0;
            err_onehot <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < N; r++)
                    mem[b][r] <= '0;
        end else begin
            full   <= full_nx;
            wbank  <= wbank_nx;
            wstate <= wstate_nx;
            rstate <= rstate_nx;
            if (flush) wrow <= '0;
            else if (write) wrow <= wdone ? '0 : wrow + 1'b1;
            if (write) begin
                mem[wbank][wrow] <= in_row;
                if ($countones(in_row) != 1) err_onehot <= 1'b1;
            end
            if (wdone && sol_count != '1) sol_count <= sol_count + 1'b1;
            if (rhs) begin
                rrow  <= rdone ? '0 : rrow + 1'b1;
                rbank <= rbank ^ rdone;
            end
        end
    end
endmodule

// File: tb/tb_queen_solution_buffer.sv
// tb_queen_solution_buffer: random-stimulus scoreboard bench; a queue model of
// captured solutions is compared against the replayed output stream.
`timescale 1ns/1ps
module tb_queen_solution_buffer;
    typedef logic [7:0] sol_t [8];

    logic       clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 0;
    logic [7:0] in_row = 0;
    logic       in_ready, out_valid, out_last, err_onehot;
    logic [7:0] out_data;
    logic [6:0] sol_count;

    int         n_chk = 0, n_fail = 0, pops = 0, ready_mode = 1;
    logic [8:0] exp_q [$];
    logic [7:0] partial [$];
    int         model_cnt = 0;
    bit         model_err = 0;
    sol_t       s1 = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};

    queen_solution_buffer #(.N(8), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_row(in_row),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sol_count(sol_count), .err_onehot(err_onehot)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic model_accept(input logic [7:0] row);
        int pc = 0;
        for (int i = 0; i < 8; i++) pc += int'(row[i] === 1'b1);
        if (pc != 1) model_err = 1;
        partial.push_back(row);
        if (partial.size() == 8) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, partial[i]});
            partial.delete();
            if (model_cnt < 127) model_cnt++;
        end
    endtask

    task automatic send_row(input logic [7:0] row);
        int cyc = 0;
        in_valid = 1; in_row = row; flush = 0;
        @(negedge clk);
        while (!in_ready && cyc < 400) begin @(negedge clk); cyc++; end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end else model_accept(row);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic flush_cycle();
        in_valid = 1; in_row = 8'h01; flush = 1;
        partial.delete();
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic send_sol(input sol_t s, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_row(s[i]);
        end
    endtask

    task automatic make_perm(output sol_t s);
        int idx [8];
        for (int i = 0; i < 8; i++) idx[i] = i;
        for (int i = 7; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = idx[i];
            idx[i] = idx[j]; idx[j] = t;
        end
        for (int i = 0; i < 8; i++) s[i] = 8'(1 << idx[i]);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1;
        exp_q.delete(); partial.delete(); model_cnt = 0; model_err = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sol_count", sol_count, 0);
        chk("rst_err", err_onehot, 0);
        repeat (2) @(posedge clk);
        #2 reset = 0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin @(posedge clk); cyc++; end
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: got %0d rows pending required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
        chk("no_extra_output", out_valid, 0);
        chk("sol_count", sol_count, model_cnt);
        chk("err_onehot", err_onehot, model_err);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // monitor: pops the scoreboard on each handshake, checks hold while stalled
    initial begin
        bit         stall = 0;
        logic [7:0] hd = 0;
        logic       hl = 0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (reset) stall = 0;
            else begin
                if (stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, hd);
                    chk("stall_last", out_last, hl);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_row: got %0h required no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e[7:0]);
                        chk("out_last", out_last, e[8]);
                        pops++;
                    end
                end
                stall = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    end

    initial begin
        sol_t s;
        int   p0, cyc;
        reset = 1;
        #12 reset = 0;

        do_reset();
        ready_mode = 1;
        send_sol(s1, 0);
        chk("t1_count", sol_count, 1);
        chk("t1_latency_low", out_valid, 0);
        @(posedge clk); #2;
        chk("t1_latency_high", out_valid, 1);
        drain();

        do_reset();
        ready_mode = 0;
        make_perm(s); send_sol(s, 0);
        make_perm(s); send_sol(s, 0);
        chk("t2_in_ready_low", in_ready, 0);
        chk("t2_count", sol_count, 2);
        p0 = pops;
        fork
            begin
                make_perm(s);
                send_sol(s, 0);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("t2_stalled_ready", in_ready, 0);
                chk("t2_stalled_count", sol_count, 2);
                ready_mode = 1;
                cyc = 0;
                while (pops < p0 + 8 && cyc < 200) begin @(posedge clk); cyc++; end
                @(posedge clk); #2;
                chk("t2_in_ready_back", in_ready, 1);
            end
        join
        drain();

        do_reset();
        for (int i = 0; i < 5; i++) send_row(s1[i]);
        flush_cycle();
        make_perm(s); send_sol(s, 0);
        drain();
        chk("t3_count", sol_count, 1);

        do_reset();
        send_row(8'h00);
        chk("t4_err_first", err_onehot, 1);
        send_row(8'h03);
        chk("t4_err_sticky", err_onehot, 1);
        for (int i = 2; i < 8; i++) send_row(s1[i]);
        drain();

        do_reset();
        ready_mode = 2;
        for (int k = 0; k < 10; k++) begin make_perm(s); send_sol(s, 1); end
        drain();

        do_reset();
        ready_mode = 1;
        p0 = pops;
        send_sol(s1, 0);
        cyc = 0;
        while (pops < p0 + 4 && cyc < 100) begin @(posedge clk); cyc++; end
        #2;
        chk("t6_sending", out_valid, 1);
        reset = 1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_count", sol_count, 0);
        exp_q.delete(); partial.delete(); model_cnt = 0; model_err = 0;
        repeat (2) @(posedge clk);
        #2 reset = 0;
        make_perm(s); send_sol(s, 0);
        drain();

        do_reset();
        for (int k = 0; k < 130; k++) begin make_perm(s); send_sol(s, 0); end
        drain();
        chk("t7_saturate", sol_count, 127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
